// File: rtl/maxpool_tester_axi_slave.sv
// maxpool_tester_axi_slave: AXI4-Lite slave with four signed inputs, two scratch words, a write counter and a signed max-pool result
//   S_AXI_ACLK/S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*         : single-outstanding write path, SLVERR on RO/unmapped words
//   S_AXI_AR*/R*            : single-outstanding read path, RDATA=0/SLVERR on unmapped words
//   map (word): 0-3 POOL_IN RW, 4-5 SCRATCH RW, 6 WR_COUNT RO, 7 POOL_MAX RO
module maxpool_tester_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  logic [DW-1:0] regs [0:5];
  logic [DW-1:0] wr_count, pool_max, rd_val, m01, m23, max_all;
  logic [IW-1:0] w_idx, r_idx;
  logic wr_rdy, rd_rdy, wr_fire, rd_fire, w_ok, r_ok;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign w_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ok = w_idx < IW'(6);
  assign r_ok = r_idx < IW'(8);
  assign wr_fire = wr_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = rd_rdy && S_AXI_ARVALID;
  assign S_AXI_AWREADY = wr_rdy;
  assign S_AXI_WREADY = wr_rdy;
  assign S_AXI_ARREADY = rd_rdy;
  assign m01 = $signed(regs[0]) > $signed(regs[1]) ? regs[0] : regs[1];
  assign m23 = $signed(regs[2]) > $signed(regs[3]) ? regs[2] : regs[3];
  assign max_all = $signed(m01) > $signed(m23) ? m01 : m23;
  always_comb begin
    rd_val = '0;
    if (r_idx < IW'(6)) rd_val = regs[r_idx[2:0]];
    else if (r_idx == IW'(6)) rd_val = wr_count;
    else if (r_idx == IW'(7)) rd_val = pool_max;
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_rdy <= 1'b0;
      rd_rdy <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP <= 2'b00;
      S_AXI_RDATA <= '0;
      wr_count <= '0;
      pool_max <= '0;
      for (int i = 0; i < 6; i++) regs[i] <= '0;
    end else begin
      // ready is a one-cycle pulse; the handshake happens on the edge that ends it
      wr_rdy <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !wr_rdy;
      rd_rdy <= S_AXI_ARVALID && !S_AXI_RVALID && !rd_rdy;
      pool_max <= max_all;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= w_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (wr_fire && w_ok) begin
        for (int b = 0; b < SW; b++)
          if (S_AXI_WSTRB[b]) regs[w_idx[2:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        wr_count <= wr_count + 1'b1;
      end
      // rd_val samples pre-edge state, so a same-edge write is not visible
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA <= rd_val;
        S_AXI_RRESP <= r_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_maxpool_tester_axi_slave.sv
// tb_maxpool_tester_axi_slave: scoreboard bench with a word-level register model for maxpool_tester_axi_slave
module tb_maxpool_tester_axi_slave;
  logic tb_ACLK = 1'b0;
  logic rst;
  logic [5:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {logic [31:0] d; logic [1:0] r;} rexp_t;
  logic [1:0] exp_b [$];
  rexp_t exp_r [$];
  logic [31:0] mdl [0:5];
  logic [31:0] mdl_cnt;

  always #5 tb_ACLK = ~tb_ACLK;

  maxpool_tester_axi_slave dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rexp_t model_read(input logic [5:0] a);
    int idx;
    int m;
    rexp_t e;
    idx = int'(a[5:2]);
    e.r = 2'b00;
    if (idx < 6) e.d = mdl[idx];
    else if (idx == 6) e.d = mdl_cnt;
    else if (idx == 7) begin
      m = $signed(mdl[0]);
      for (int i = 1; i < 4; i++) if ($signed(mdl[i]) > m) m = $signed(mdl[i]);
      e.d = 32'(m);
    end else begin
      e.d = 32'h0;
      e.r = 2'b10;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mdl[i] = 32'h0;
    mdl_cnt = 32'h0;
  endtask

  task automatic sync();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic start_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    if (idx < 6) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      mdl_cnt = mdl_cnt + 1;
      exp_b.push_back(2'b00);
    end else exp_b.push_back(2'b10);
    AWADDR = a;
    WDATA = d;
    WSTRB = s;
    AWVALID = 1'b1;
    WVALID = 1'b1;
  endtask

  task automatic finish_write();
    int n;
    n = 0;
    do begin
      @(negedge tb_ACLK);
      n++;
    end while (!AWREADY && n < 40);
    chk("awready_accept", 32'(AWREADY), 1);
    chk("wready_accept", 32'(WREADY), 1);
    chk("no_accept_while_bvalid", 32'(BVALID), 0);
    sync();
    AWVALID = 1'b0;
    WVALID = 1'b0;
    @(negedge tb_ACLK);
    chk("awready_pulse", 32'(AWREADY), 0);
    chk("bvalid_rise", 32'(BVALID), 1);
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (exp_b.size() != 0 && n < 40) begin
      @(negedge tb_ACLK);
      n++;
    end
    chk("b_drain", 32'(exp_b.size()), 0);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    sync();
    start_write(a, d, s);
    finish_write();
    wait_b();
  endtask

  task automatic start_read(input logic [5:0] a);
    exp_r.push_back(model_read(a));
    ARADDR = a;
    ARVALID = 1'b1;
  endtask

  task automatic finish_read();
    int n;
    n = 0;
    do begin
      @(negedge tb_ACLK);
      n++;
    end while (!ARREADY && n < 40);
    chk("arready_accept", 32'(ARREADY), 1);
    sync();
    ARVALID = 1'b0;
    @(negedge tb_ACLK);
    chk("arready_pulse", 32'(ARREADY), 0);
    chk("rvalid_rise", 32'(RVALID), 1);
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    while (exp_r.size() != 0 && n < 40) begin
      @(negedge tb_ACLK);
      n++;
    end
    chk("r_drain", 32'(exp_r.size()), 0);
  endtask

  task automatic do_read(input logic [5:0] a);
    sync();
    start_read(a);
    finish_read();
    wait_r();
  endtask

  always @(negedge tb_ACLK) begin
    if (!rst) begin
      if (BVALID) begin
        if (exp_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bvalid_unexpected: got BVALID=1 expected no response at %0t", $time);
        end else begin
          chk("bresp", 32'(BRESP), 32'(exp_b[0]));
          if (BREADY) void'(exp_b.pop_front());
        end
      end
      if (RVALID) begin
        if (exp_r.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rvalid_unexpected: got RVALID=1 expected no response at %0t", $time);
        end else begin
          chk("rdata", RDATA, exp_r[0].d);
          chk("rresp", 32'(RRESP), 32'(exp_r[0].r));
          if (RREADY) void'(exp_r.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] wi, ri;
    rst = 1'b1;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    WDATA = '0; WSTRB = '0;
    BREADY = 1'b1; RREADY = 1'b1;
    model_reset();
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_wready", 32'(WREADY), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_bresp", 32'(BRESP), 0);
    chk("rst_rresp", 32'(RRESP), 0);
    chk("rst_rdata", RDATA, 0);
    sync();
    rst = 1'b0;

    do_write(6'h10, 32'h12345678, 4'hF);
    do_read(6'h10);
    do_read(6'h18);

    do_write(6'h00, 32'hFFFFFFFB, 4'hF);
    do_write(6'h04, 32'h00000007, 4'hF);
    do_write(6'h08, 32'h80000000, 4'hF);
    do_write(6'h0C, 32'h00000003, 4'hF);
    do_read(6'h1C);

    do_write(6'h14, 32'hFFFFFFFF, 4'hF);
    do_write(6'h14, 32'h00000000, 4'h5);
    do_read(6'h14);

    do_write(6'h18, 32'hDEADBEEF, 4'hF);
    do_write(6'h20, 32'hDEADBEEF, 4'hF);
    do_read(6'h3C);
    do_read(6'h18);

    sync();
    start_read(6'h10);
    start_write(6'h10, 32'hCAFEF00D, 4'hF);
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("same_edge_awready", 32'(AWREADY), 1);
    chk("same_edge_arready", 32'(ARREADY), 1);
    sync();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    wait_b();
    wait_r();
    do_read(6'h10);

    sync();
    BREADY = 1'b0;
    start_write(6'h18, 32'h1, 4'hF);
    finish_write();
    sync();
    start_write(6'h14, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_ACLK);
      chk("bvalid_hold", 32'(BVALID), 1);
      chk("second_write_stalled", 32'(AWREADY), 0);
    end
    sync();
    BREADY = 1'b1;
    finish_write();
    wait_b();
    do_read(6'h14);

    for (int i = 0; i < 80; i++) begin
      wi = 4'($urandom_range(0, 15));
      do_write({wi, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        ri = 4'($urandom_range(0, 15));
        do_read({ri, 2'b00});
      end
    end
    for (int i = 0; i < 16; i++) do_read(6'(i * 4));

    sync();
    RREADY = 1'b0;
    start_read(6'h1C);
    finish_read();
    sync();
    rst = 1'b1;
    exp_r.delete();
    exp_b.delete();
    model_reset();
    sync();
    rst = 1'b0;
    @(negedge tb_ACLK);
    chk("rst_drops_rvalid", 32'(RVALID), 0);
    chk("rst_clears_rdata", RDATA, 0);
    RREADY = 1'b1;
    for (int i = 0; i < 16; i++) do_read(6'(i * 4));

    repeat (3) @(posedge tb_ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
